pwm_seq: RTL and testbench
==========================

// Module: pwm_seq
// PURPOSE
// Table-driven sample sequencer that sits directly upstream of pwm/pdm. It
// drives their str_dat/str_vld/str_rdy stream from a 2**AW-entry pattern table
// of CHN x DWC words. The CPU loads the table through a simple write port, then
// starts playback in one-shot or loop mode. Each entry is held for a
// programmable repeat count. Gap-free: one beat per cycle when str_rdy stays high.
// PARAMETERS
// DWC  4  sample width (matches pwm/pdm DWC)
// CHN  4  channels per beat (matches pwm/pdm CHN)
// AW   4  table address width, depth 2**AW
// CNW  8  repeat counter width
// PORTS
// clk       in  1          clock
// rstn      in  1          reset, asynchronous, active-low
// ctl_start in  1          start pulse
// ctl_stop  in  1          stop pulse
// cfg_len   in  AW         index of last table entry
// cfg_mode  in  1          0 one-shot, 1 loop
// cfg_rpt   in  CNW        beats per entry minus 1
// wr_en     in  1          table write strobe
// wr_adr    in  AW         table write address
// wr_dat    in  CHN*DWC    table write data, channel 0 in LSBs
// str_dat   out CHN x DWC  stream data to pwm/pdm
// str_vld   out 1          stream valid
// str_rdy   in  1          stream ready
// sts_busy  out 1          high in FETCH/RUN
// sts_ptr   out AW         index of entry currently on str_dat
// BEHAVIOUR
// - Reset: clk is the only clock. rstn is asynchronous and active-low. It
//   clears str_vld, sts_busy, sts_ptr and str_dat to 0 and state to IDLE.
//   Table contents are not reset. Reset mid-run drops str_vld immediately.
// - FSM IDLE->FETCH->RUN->IDLE.
// - IDLE: ctl_start & !ctl_stop latches cfg_len/cfg_mode/cfg_rpt and sets
//   read address 0, then -> FETCH. Config changes have no effect until the next start.
// - FETCH: single cycle. str_dat<=table[0], sts_ptr<=0, str_vld<=1, rpt_cnt<=0.
//   Read address is set to next(0). -> RUN.
// - Latency: start in cycle n gives str_vld=1 with entry 0 in cycle n+2.
// - RUN: beat = str_vld & str_rdy.
//   - Without a beat, str_dat/str_vld/sts_ptr hold stable (no retraction).
//   - On a beat with rpt_cnt<cfg_rpt: rpt_cnt++ and data is held.
//   - On a beat with rpt_cnt==cfg_rpt: rpt_cnt<=0, sts_ptr<=nxt, str_dat<=mem_q.
// - next(p) = (p==cfg_len) ? 0 : p+1.
// - Table read is synchronous (1 cycle).
//   - rd_adr = advancing ? next(nxt) : nxt, so mem_q always holds table[nxt].
//   - This gives zero bubbles.
// - One-shot end: the final beat of entry cfg_len sets str_vld<=0 and moves to IDLE.
// - Loop: wraps cfg_len->0 with no gap. cfg_len=0 repeats entry 0 indefinitely.
// - Stop: ctl_stop in RUN sets stop_pend. The current str_vld is held until its
//   beat, then str_vld<=0 and -> IDLE. If that beat happens in the same cycle,
//   the stop takes effect in that cycle. Stop in FETCH is honoured on the first beat.
// - ctl_start while busy is ignored. start&stop together in IDLE does nothing.
// - Write: wr_en writes table[wr_adr] in any state. When wr_adr==rd_adr in the
//   same cycle, the read returns the old data (read-first). The new value appears
//   on the next pass.
// - In IDLE, str_dat keeps the last beat (pwm/pdm latch only on handshake).
// - sts_busy = (state != IDLE).
// STRUCTURE
// - pwm_pkg: typedef enum {IDLE,FETCH,RUN} pwm_seq_st_t; localparams MODE_ONESHOT=0, MODE_LOOP=1.
// - Sub-module pwm_seq_ram: simple dual-port, synchronous read-first, 2**AW x CHN*DWC.
// - Top holds the FSM, pointers, repeat counter and output register.
// TESTING (DWC=4, CHN=4, AW=4, CNW=8; table[i]={CHN{i[3:0]}}; clkdiv div=7 feeds pwm cke)
// - Reset: rstn=0 for 4 clk -> str_vld=0, str_dat=0, sts_busy=0, sts_ptr=0.
//   Pull rstn low mid-RUN -> str_vld=0 with no clk edge.
// - One-shot: len=3, rpt=0, str_rdy=1, start at cycle 0 -> str_vld 1 in cycles 2..5
//   with data 0,1,2,3 -> str_vld=0 and sts_busy=0 in cycle 6.
// - Loop+repeat: mode=1, len=1, rpt=2, str_rdy=1 -> beat data 0,0,0,1,1,1,0,0,0...
//   sts_ptr tracks the data.
// - Backpressure: driven by pwm str_rdy (1 beat per 2**DWC cke). str_dat stays
//   stable while str_rdy=0. Sequence 0..15 exact, no loss or duplication.
// - Stop: in loop, ctl_stop pulse with str_rdy=0 for 5 cycles -> str_vld held 5
//   cycles, drops the cycle after the beat, then IDLE. Start during RUN is ignored.
// - Write collision: during loop len=3, write table[2]=16'hAAAA while rd_adr==2
//   -> the current pass emits 2222, the next pass emits AAAA.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types for the pattern-table sample sequencer.
//   pwm_seq_st_t  : sequencer FSM state
//   MODE_ONESHOT  : play entries 0..cfg_len once, then return to IDLE
//   MODE_LOOP     : wrap from cfg_len back to 0 until stopped
package pwm_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RUN   = 2'd2
   } pwm_seq_st_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_LOOP    = 1'b1;

endpackage

// File: rtl/pwm_seq_if.sv
// Sample stream between the sequencer and pwm/pdm.
//   str_dat : CHN x DWC samples, channel 0 in the low bits
//   str_vld : beat valid (source)
//   str_rdy : beat accept (sink)
interface pwm_seq_if #(
   parameter int DWC = 4,
   parameter int CHN = 4
);
   logic [CHN-1:0][DWC-1:0] str_dat;
   logic                    str_vld;
   logic                    str_rdy;

   modport master (output str_dat, output str_vld, input str_rdy);
   modport slave  (input str_dat, input str_vld, output str_rdy);
endinterface

// File: rtl/pwm_seq_ram.sv
// Pattern table: simple dual-port RAM, synchronous read, read-first on a
// same-address collision. Contents are not reset.
//   clk      : clock
//   wr_en_i  : write strobe
//   wr_adr_i : write address
//   wr_dat_i : write data
//   rd_adr_i : read address, sampled every cycle
//   rd_dat_o : data at rd_adr_i from the previous cycle
module pwm_seq_ram #(
   parameter int AW = 4,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_adr_i,
   input  logic [DW-1:0] wr_dat_i,
   input  logic [AW-1:0] rd_adr_i,
   output logic [DW-1:0] rd_dat_o
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_adr_i] <= wr_dat_i;
      end
      rd_dat_o <= mem[rd_adr_i];
   end

endmodule

// File: rtl/pwm_seq.sv
// Table-driven sample sequencer feeding the pwm/pdm stream.
//   clk, rstn                  : clock, async active-low reset
//   ctl_start, ctl_stop        : control pulses
//   cfg_len, cfg_mode, cfg_rpt : last entry, one-shot/loop, beats per entry - 1
//   wr_en, wr_adr, wr_dat      : table write port
//   str                        : sample stream (master side)
//   sts_busy, sts_ptr          : running flag, index of entry on str_dat
//
// state | meaning
// IDLE  | waiting for start; str_dat keeps the last beat
// FETCH | one cycle: load entry 0 into the output register
// RUN   | presenting entries, each for cfg_rpt+1 beats
module pwm_seq
   import pwm_seq_pkg::*;
#(
   parameter int DWC = 4,
   parameter int CHN = 4,
   parameter int AW  = 4,
   parameter int CNW = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               ctl_start,
   input  logic               ctl_stop,
   input  logic [AW-1:0]      cfg_len,
   input  logic               cfg_mode,
   input  logic [CNW-1:0]     cfg_rpt,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_adr,
   input  logic [CHN*DWC-1:0] wr_dat,
   pwm_seq_if.master          str,
   output logic               sts_busy,
   output logic [AW-1:0]      sts_ptr
);

   localparam int DW = CHN * DWC;

   pwm_seq_st_t  state_q, state_d;
   logic [AW-1:0]  len_q, len_d;
   logic           mode_q, mode_d;
   logic [CNW-1:0] rpt_q, rpt_d;
   logic [CNW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [AW-1:0]  nxt_q, nxt_d;
   logic [AW-1:0]  ptr_q, ptr_d;
   logic [DW-1:0]  dat_q, dat_d;
   logic           vld_q, vld_d;
   logic           stop_pend_q, stop_pend_d;

   logic [AW-1:0]  rd_adr;
   logic [DW-1:0]  mem_q;
   logic           start_ok, beat, advance, finish;

   function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] p);
      return (p == len_q) ? '0 : p + 1'b1;
   endfunction

   pwm_seq_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk      (clk),
      .wr_en_i  (wr_en),
      .wr_adr_i (wr_adr),
      .wr_dat_i (wr_dat),
      .rd_adr_i (rd_adr),
      .rd_dat_o (mem_q)
   );

   assign start_ok = ctl_start & ~ctl_stop;
   assign beat     = vld_q & str.str_rdy;
   assign advance  = (state_q == RUN) & beat & (rpt_cnt_q == rpt_q);
   // A stop requested in this very cycle still counts if its beat lands now.
   assign finish   = (state_q == RUN) & beat &
                     (stop_pend_q | ctl_stop |
                      (advance & (mode_q == MODE_ONESHOT) & (ptr_q == len_q)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         len_q       <= '0;
         mode_q      <= MODE_ONESHOT;
         rpt_q       <= '0;
         rpt_cnt_q   <= '0;
         nxt_q       <= '0;
         ptr_q       <= '0;
         dat_q       <= '0;
         vld_q       <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         rpt_q       <= rpt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         nxt_q       <= nxt_d;
         ptr_q       <= ptr_d;
         dat_q       <= dat_d;
         vld_q       <= vld_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = FETCH;
         FETCH:   state_d = RUN;
         RUN:     if (finish) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // rd_adr always targets the entry that will be needed at the next
   // advance, so mem_q holds table[nxt_q] and entries follow with no bubble.
   always_comb begin
      len_d       = len_q;
      mode_d      = mode_q;
      rpt_d       = rpt_q;
      rpt_cnt_d   = rpt_cnt_q;
      nxt_d       = nxt_q;
      ptr_d       = ptr_q;
      dat_d       = dat_q;
      vld_d       = vld_q;
      stop_pend_d = stop_pend_q;
      rd_adr      = nxt_q;
      case (state_q)
         IDLE: begin
            rd_adr = '0;
            if (start_ok) begin
               len_d       = cfg_len;
               mode_d      = (cfg_mode == MODE_LOOP) ? MODE_LOOP : MODE_ONESHOT;
               rpt_d       = cfg_rpt;
               stop_pend_d = 1'b0;
            end
         end
         FETCH: begin
            dat_d       = mem_q;
            ptr_d       = '0;
            vld_d       = 1'b1;
            rpt_cnt_d   = '0;
            nxt_d       = next_idx('0);
            rd_adr      = next_idx('0);
            stop_pend_d = stop_pend_q | ctl_stop;
         end
         RUN: begin
            stop_pend_d = stop_pend_q | ctl_stop;
            if (finish) begin
               vld_d       = 1'b0;
               stop_pend_d = 1'b0;
            end else if (advance) begin
               rpt_cnt_d = '0;
               ptr_d     = nxt_q;
               dat_d     = mem_q;
               nxt_d     = next_idx(nxt_q);
               rd_adr    = next_idx(nxt_q);
            end else if (beat) begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign str.str_dat = dat_q;
   assign str.str_vld = vld_q;
   assign sts_busy    = (state_q != IDLE);
   assign sts_ptr     = ptr_q;

endmodule

// File: tb/tb_pwm_seq.sv
module tb_pwm_seq;
   import pwm_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        ctl_start = 1'b0;
   logic        ctl_stop = 1'b0;
   logic [3:0]  cfg_len = '0;
   logic        cfg_mode = 1'b0;
   logic [7:0]  cfg_rpt = '0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_adr = '0;
   logic [15:0] wr_dat = '0;
   logic        sts_busy;
   logic [3:0]  sts_ptr;
   logic [15:0] dat_flat;

   int n_tests = 0;
   int n_fail  = 0;

   pwm_seq_if #(.DWC(4), .CHN(4)) str_if ();

   pwm_seq #(.DWC(4), .CHN(4), .AW(4), .CNW(8)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .ctl_start (ctl_start),
      .ctl_stop  (ctl_stop),
      .cfg_len   (cfg_len),
      .cfg_mode  (cfg_mode),
      .cfg_rpt   (cfg_rpt),
      .wr_en     (wr_en),
      .wr_adr    (wr_adr),
      .wr_dat    (wr_dat),
      .str       (str_if),
      .sts_busy  (sts_busy),
      .sts_ptr   (sts_ptr)
   );

   assign dat_flat = str_if.str_dat;

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        stop;
      logic        rdy;
      logic [3:0]  len;
      logic        mode;
      logic [7:0]  rpt;
      logic        e_vld;
      logic        e_busy;
      logic [3:0]  e_ptr;
      logic [15:0] e_dat;
   } vec_t;

   vec_t vq[$];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic sp, input logic rdy,
                      input logic [3:0] len, input logic mode, input logic [7:0] rpt,
                      input logic ev, input logic eb, input logic [3:0] ep,
                      input logic [15:0] ed);
      vec_t v;
      v.start = st; v.stop = sp; v.rdy = rdy;
      v.len = len; v.mode = mode; v.rpt = rpt;
      v.e_vld = ev; v.e_busy = eb; v.e_ptr = ep; v.e_dat = ed;
      vq.push_back(v);
   endtask

   task automatic chk_out(input string nm, input logic ev, input logic eb,
                          input logic [3:0] ep, input logic [15:0] ed);
      chk({nm, ".vld"},  32'(str_if.str_vld), 32'(ev));
      chk({nm, ".busy"}, 32'(sts_busy),       32'(eb));
      chk({nm, ".ptr"},  32'(sts_ptr),        32'(ep));
      chk({nm, ".dat"},  32'(dat_flat),       32'(ed));
   endtask

   initial begin
      logic [15:0] exp_list [7];
      logic [15:0] prev_dat;
      logic        prev_stall;
      int          beats;
      int          cyc;
      logic        done;

      str_if.str_rdy = 1'b0;

      // ---------------- reset ----------------
      repeat (4) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 1'b0, 4'd0, 16'h0000);
      rstn = 1'b1;
      tick;
      chk_out("post_reset", 1'b0, 1'b0, 4'd0, 16'h0000);

      // table[i] = {4{i}}
      for (int i = 0; i < 16; i++) begin
         wr_en  = 1'b1;
         wr_adr = 4'(i);
         wr_dat = 16'h1111 * 16'(i);
         tick;
      end
      wr_en = 1'b0;

      // ---------------- vector table ----------------
      // one-shot len=3 rpt=0; config is scrambled after start to show it is latched
      add(1,0,1, 4'd3, 1'b0, 8'd0,  0,1,4'd0,16'h0000);
      add(0,0,1, 4'd15,1'b1, 8'd5,  1,1,4'd0,16'h0000);
      add(0,0,1, 4'd15,1'b1, 8'd5,  1,1,4'd1,16'h1111);
      add(0,0,1, 4'd15,1'b1, 8'd5,  1,1,4'd2,16'h2222);
      add(0,0,1, 4'd15,1'b1, 8'd5,  1,1,4'd3,16'h3333);
      add(0,0,1, 4'd15,1'b1, 8'd5,  0,0,4'd3,16'h3333);
      add(0,0,1, 4'd15,1'b1, 8'd5,  0,0,4'd3,16'h3333);
      // loop len=1 rpt=2
      add(1,0,1, 4'd1, 1'b1, 8'd2,  0,1,4'd3,16'h3333);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd1,16'h1111);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd1,16'h1111);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd1,16'h1111);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      add(0,0,1, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      add(0,0,0, 4'd0, 1'b0, 8'd0,  1,1,4'd0,16'h0000);
      // stop with a beat in the same cycle takes effect immediately
      add(0,1,1, 4'd0, 1'b0, 8'd0,  0,0,4'd0,16'h0000);
      // start together with stop in IDLE does nothing
      add(1,1,1, 4'd2, 1'b1, 8'd0,  0,0,4'd0,16'h0000);
      add(0,0,1, 4'd2, 1'b1, 8'd0,  0,0,4'd0,16'h0000);

      foreach (vq[i]) begin
         ctl_start      = vq[i].start;
         ctl_stop       = vq[i].stop;
         str_if.str_rdy = vq[i].rdy;
         cfg_len        = vq[i].len;
         cfg_mode       = vq[i].mode;
         cfg_rpt        = vq[i].rpt;
         tick;
         chk_out($sformatf("vec%0d", i), vq[i].e_vld, vq[i].e_busy, vq[i].e_ptr, vq[i].e_dat);
      end
      ctl_start = 1'b0;
      ctl_stop  = 1'b0;

      // ---------------- backpressure: one-shot 0..15, rdy one cycle in three ----------------
      cfg_len = 4'd15; cfg_mode = MODE_ONESHOT; cfg_rpt = 8'd0;
      str_if.str_rdy = 1'b0;
      ctl_start = 1'b1;
      tick;
      ctl_start = 1'b0;
      beats = 0; prev_stall = 1'b0; prev_dat = '0; done = 1'b0;
      for (cyc = 0; cyc < 200 && !done; cyc++) begin
         if (prev_stall) begin
            chk("bp_hold_vld", 32'(str_if.str_vld), 32'd1);
            chk("bp_hold_dat", 32'(dat_flat), 32'(prev_dat));
         end
         str_if.str_rdy = (cyc % 3 == 2);
         if (str_if.str_vld && str_if.str_rdy) begin
            chk($sformatf("bp_beat%0d_dat", beats), 32'(dat_flat), 32'(16'h1111 * 16'(beats)));
            chk($sformatf("bp_beat%0d_ptr", beats), 32'(sts_ptr), 32'(beats));
            beats++;
         end
         prev_stall = str_if.str_vld && !str_if.str_rdy;
         prev_dat   = dat_flat;
         if (!sts_busy && cyc > 0) done = 1'b1;
         else tick;
      end
      chk("bp_no_timeout", 32'(done), 32'd1);
      chk("bp_beat_count", 32'(beats), 32'd16);
      chk("bp_end_vld", 32'(str_if.str_vld), 32'd0);

      // ---------------- stop under backpressure; start while busy ignored ----------------
      cfg_len = 4'd1; cfg_mode = MODE_LOOP; cfg_rpt = 8'd2;
      str_if.str_rdy = 1'b1;
      ctl_start = 1'b1;
      tick;
      ctl_start = 1'b0;
      repeat (4) tick;
      chk_out("stop_pre", 1'b1, 1'b1, 4'd1, 16'h1111);
      str_if.str_rdy = 1'b0;
      ctl_stop  = 1'b1;
      ctl_start = 1'b1;
      cfg_len   = 4'd0;
      tick;
      ctl_stop  = 1'b0;
      ctl_start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk_out($sformatf("stop_hold%0d", k), 1'b1, 1'b1, 4'd1, 16'h1111);
         if (k == 5) str_if.str_rdy = 1'b1;
         tick;
      end
      chk_out("stop_done", 1'b0, 1'b0, 4'd1, 16'h1111);

      // ---------------- write collision (read-first) ----------------
      cfg_len = 4'd3; cfg_mode = MODE_LOOP; cfg_rpt = 8'd0;
      str_if.str_rdy = 1'b1;
      ctl_start = 1'b1;
      tick;
      ctl_start = 1'b0;
      tick;
      chk_out("wc_first", 1'b1, 1'b1, 4'd0, 16'h0000);
      wr_en = 1'b1; wr_adr = 4'd2; wr_dat = 16'hAAAA;
      tick;
      wr_en = 1'b0;
      exp_list[0] = 16'h1111; exp_list[1] = 16'h2222; exp_list[2] = 16'h3333;
      exp_list[3] = 16'h0000; exp_list[4] = 16'h1111; exp_list[5] = 16'hAAAA;
      exp_list[6] = 16'h3333;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("wc_dat%0d", k), 32'(dat_flat), 32'(exp_list[k]));
         chk($sformatf("wc_ptr%0d", k), 32'(sts_ptr), 32'((k + 1) % 4));
         tick;
      end
      ctl_stop = 1'b1;
      tick;
      ctl_stop = 1'b0;
      chk("wc_stopped", 32'(sts_busy), 32'd0);

      // ---------------- reset mid-run ----------------
      cfg_len = 4'd3; cfg_mode = MODE_LOOP; cfg_rpt = 8'd0;
      ctl_start = 1'b1;
      tick;
      ctl_start = 1'b0;
      repeat (3) tick;
      chk("rr_running", 32'(str_if.str_vld), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk_out("rr_async", 1'b0, 1'b0, 4'd0, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      tick;
      chk_out("rr_after", 1'b0, 1'b0, 4'd0, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
